// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALU operations, mux selects and instruction classes.
package mips_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_R_ALU, C_I_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_JR, C_ILLEGAL
   } iclass_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_LUI  = 3'd3;

   localparam logic [1:0] RD_RT    = 2'd0;
   localparam logic [1:0] RD_RD    = 2'd1;
   localparam logic [1:0] RD_RA    = 2'd2;

   localparam logic [1:0] WS_ALU   = 2'd0;
   localparam logic [1:0] WS_MEM   = 2'd1;
   localparam logic [1:0] WS_PC4   = 2'd2;

   localparam logic [1:0] NPC_PC4  = 2'd0;
   localparam logic [1:0] NPC_BR   = 2'd1;
   localparam logic [1:0] NPC_J    = 2'd2;
   localparam logic [1:0] NPC_JR   = 2'd3;

   function automatic logic [5:0] f_opcode(input logic [31:0] ins);
      return ins[31:26];
   endfunction

   function automatic logic [5:0] f_funct(input logic [31:0] ins);
      return ins[5:0];
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class,
// plus whether the instruction can raise signed overflow.
module mc_decode
   import mips_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output iclass_t    o_cls,
   output logic       o_ovf_capable
);

   always_comb begin
      o_cls         = C_ILLEGAL;
      o_ovf_capable = 1'b0;
      case (i_opcode)
         OP_RTYPE: begin
            case (i_funct)
               FN_ADDU, FN_SUBU: o_cls = C_R_ALU;
               FN_ADD: begin
                  o_cls         = C_R_ALU;
                  o_ovf_capable = 1'b1;
               end
               FN_JR:   o_cls = C_JR;
               default: o_cls = C_ILLEGAL;
            endcase
         end
         OP_ORI, OP_LUI: o_cls = C_I_ALU;
         OP_ADDI: begin
            o_cls         = C_I_ALU;
            o_ovf_capable = 1'b1;
         end
         OP_LW:   o_cls = C_LOAD;
         OP_SW:   o_cls = C_STORE;
         OP_BEQ:  o_cls = C_BRANCH;
         OP_J:    o_cls = C_JUMP;
         OP_JAL:  o_cls = C_JAL;
         default: o_cls = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb over a
// req/ready memory handshake and counts retired instructions.
module mc_ctrl
   import mips_pkg::*;
#(
   parameter bit OVF_TRAP = 1'b0,
   parameter int CNT_W    = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             zero,
   input  logic             overflow,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_sel,
   output logic             mem_wr,
   output logic             pc_wr,
   output logic             ir_wr,
   output logic             reg_wr,
   output logic             epc_wr,
   output logic [1:0]       reg_dst,
   output logic [1:0]       reg_wsel,
   output logic [2:0]       alu_sel,
   output logic             b_sel,
   output logic             ext_op,
   output logic [1:0]       npc_sel,
   output logic             illegal,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   state_t           r_state, w_next;
   logic             r_run;
   logic             r_ovf_sup;
   logic [CNT_W-1:0] r_retired;
   iclass_t          w_cls;
   logic             w_ovf_cap;
   logic             w_ovf_hit;
   logic             w_retire;
   logic [5:0]       w_op, w_fn;
   logic             w_unused_instr;

   assign w_op           = f_opcode(instr);
   assign w_fn           = f_funct(instr);
   assign w_unused_instr = ^instr[25:6];
   assign w_ovf_hit      = w_ovf_cap & overflow;

   mc_decode u_decode (
      .i_opcode      (w_op),
      .i_funct       (w_fn),
      .o_cls         (w_cls),
      .o_ovf_capable (w_ovf_cap)
   );

   // r_run keeps every output low during reset and the first edge after it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_run   <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (r_run && mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (w_cls)
               C_JUMP, C_JAL, C_JR, C_ILLEGAL: w_next = S_FETCH;
               default:                        w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (w_cls)
               C_BRANCH:         w_next = S_FETCH;
               C_LOAD, C_STORE:  w_next = S_MEM;
               default:          w_next = (OVF_TRAP && w_ovf_hit) ? S_TRAP : S_WB;
            endcase
         end
         S_MEM:    if (mem_ready) w_next = (w_cls == C_STORE) ? S_FETCH : S_WB;
         S_WB:     w_next = S_FETCH;
         S_TRAP:   w_next = S_FETCH;
         default:  w_next = S_FETCH;
      endcase
   end

   assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP)
                     && !((r_state == S_DECODE) && (w_cls == C_ILLEGAL));

   // Suppress decision is frozen on leaving EXEC so overflow changes in WB are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retired <= '0;
         r_ovf_sup <= 1'b0;
      end else begin
         if (w_retire) r_retired <= r_retired + CNT_W'(1);
         if (r_state == S_EXEC) r_ovf_sup <= (OVF_TRAP == 1'b0) && w_ovf_hit;
      end
   end

   always_comb begin
      mem_req  = 1'b0;
      mem_sel  = 1'b0;
      mem_wr   = 1'b0;
      pc_wr    = 1'b0;
      ir_wr    = 1'b0;
      reg_wr   = 1'b0;
      epc_wr   = 1'b0;
      reg_dst  = RD_RT;
      reg_wsel = WS_ALU;
      alu_sel  = ALU_ADD;
      b_sel    = 1'b0;
      ext_op   = 1'b0;
      npc_sel  = NPC_PC4;
      illegal  = 1'b0;
      if (r_run) begin
         case (r_state)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_wr = 1'b1;
                  pc_wr = 1'b1;
               end
            end
            S_DECODE: begin
               case (w_cls)
                  C_JUMP: begin
                     pc_wr   = 1'b1;
                     npc_sel = NPC_J;
                  end
                  C_JAL: begin
                     pc_wr    = 1'b1;
                     npc_sel  = NPC_J;
                     reg_wr   = 1'b1;
                     reg_dst  = RD_RA;
                     reg_wsel = WS_PC4;
                  end
                  C_JR: begin
                     pc_wr   = 1'b1;
                     npc_sel = NPC_JR;
                  end
                  C_ILLEGAL: illegal = 1'b1;
                  default: ;
               endcase
            end
            S_EXEC: begin
               case (w_cls)
                  C_R_ALU: alu_sel = (w_fn == FN_SUBU) ? ALU_SUB : ALU_ADD;
                  C_I_ALU: begin
                     b_sel = 1'b1;
                     case (w_op)
                        OP_ORI:  alu_sel = ALU_OR;
                        OP_LUI:  alu_sel = ALU_LUI;
                        default: begin
                           alu_sel = ALU_ADD;
                           ext_op  = 1'b1;
                        end
                     endcase
                  end
                  C_LOAD, C_STORE: begin
                     alu_sel = ALU_ADD;
                     b_sel   = 1'b1;
                     ext_op  = 1'b1;
                  end
                  C_BRANCH: begin
                     alu_sel = ALU_SUB;
                     if (zero) begin
                        pc_wr   = 1'b1;
                        npc_sel = NPC_BR;
                     end
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_sel = 1'b1;
               mem_wr  = (w_cls == C_STORE);
            end
            S_WB: begin
               reg_wr = !r_ovf_sup;
               case (w_cls)
                  C_R_ALU: reg_dst = RD_RD;
                  C_LOAD:  reg_wsel = WS_MEM;
                  default: ;
               endcase
            end
            S_TRAP: begin
               epc_wr  = 1'b1;
               pc_wr   = 1'b1;
               npc_sel = NPC_JR;
            end
            default: ;
         endcase
      end
   end

   assign state   = r_state;
   assign retired = r_retired;

endmodule
